// File: rtl/rom_loader.sv
// Load sequencer for the NROM image store: validates an iNES header and streams
// the whole image into the ROM store's program port while holding the CPU in reset.
module rom_loader #(
  parameter int IMG_BYTES = 'h6010
) (
  input  logic        ppu_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        prog,
  output logic [15:0] prog_ab,
  output logic [7:0]  prog_di,
  output logic        cpu_rst,
  output logic        done,
  output logic        err,
  output logic [15:0] byte_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_BODY   = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [15:0] LAST_IDX = 16'(IMG_BYTES - 1);
  localparam logic [15:0] HDR_LAST = 16'd15;

  logic [2:0] state;
  logic       xfer;
  logic       hdr_ok;

  assign in_ready = (state == S_HEADER) || (state == S_BODY);
  assign xfer     = in_valid && in_ready;

  // Only NROM-128 (one PRG bank, one CHR bank, no trainer, mapper 0) is accepted.
  always_comb begin
    hdr_ok = 1'b1;
    case (byte_cnt)
      16'd0:   hdr_ok = (in_data == 8'h4E);
      16'd1:   hdr_ok = (in_data == 8'h45);
      16'd2:   hdr_ok = (in_data == 8'h53);
      16'd3:   hdr_ok = (in_data == 8'h1A);
      16'd4:   hdr_ok = (in_data == 8'h01);
      16'd5:   hdr_ok = (in_data == 8'h01);
      16'd6:   hdr_ok = (in_data[7:4] == 4'h0) && !in_data[2];
      16'd7:   hdr_ok = (in_data[7:4] == 4'h0);
      default: hdr_ok = 1'b1;
    endcase
  end

  always_ff @(posedge ppu_clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      prog     <= 1'b0;
      prog_ab  <= 16'h0000;
      prog_di  <= 8'h00;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      byte_cnt <= 16'h0000;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          prog <= 1'b0;
          if (start) begin
            state    <= S_HEADER;
            byte_cnt <= 16'h0000;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_rst  <= 1'b1;
          end
        end
        S_HEADER, S_BODY: begin
          if (xfer) begin
            prog_ab  <= byte_cnt;
            prog_di  <= in_data;
            prog     <= 1'b1;
            byte_cnt <= byte_cnt + 16'd1;
            // A rejected byte is still written once; ERROR then drops prog.
            if ((state == S_HEADER) && !hdr_ok) begin
              state <= S_ERROR;
              err   <= 1'b1;
            end else if (byte_cnt == LAST_IDX) begin
              state <= S_FLUSH;
            end else if ((state == S_HEADER) && (byte_cnt == HDR_LAST)) begin
              state <= S_BODY;
            end
          end
        end
        S_FLUSH: begin
          prog    <= 1'b0;
          prog_ab <= 16'h0000;
          done    <= 1'b1;
          cpu_rst <= 1'b0;
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: random iNES images are streamed in and every
// ROM write is checked against a header/image model kept in the bench.
module tb_rom_loader;

  localparam int N = 'h6010;

  logic        ppu_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        prog;
  logic [15:0] prog_ab;
  logic [7:0]  prog_di;
  logic        cpu_rst;
  logic        done;
  logic        err;
  logic [15:0] byte_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img [N];
  logic [23:0] exp_q [$];
  logic        mon_prev_prog = 1'b0;
  logic [15:0] mon_prev_ab = 16'h0000;

  rom_loader #(.IMG_BYTES(N)) dut (
    .ppu_clk (ppu_clk),
    .rst     (rst),
    .start   (start),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .prog    (prog),
    .prog_ab (prog_ab),
    .prog_di (prog_di),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err),
    .byte_cnt(byte_cnt)
  );

  always #5 ppu_clk = ~ppu_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge ppu_clk);
    #1;
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Image model: magic, one PRG bank, one CHR bank, flag bits outside the checked masks random.
  task automatic build_image(input int kind, input bit rnd);
    for (int i = 0; i < N; i++) img[i] = rnd ? 8'($urandom) : 8'(i);
    for (int i = 8; i < 16; i++) if (!rnd) img[i] = 8'h00;
    img[0] = 8'h4E; img[1] = 8'h45; img[2] = 8'h53; img[3] = 8'h1A;
    img[4] = 8'h01; img[5] = 8'h01;
    img[6] = rnd ? (8'($urandom) & 8'h0B) : 8'h00;
    img[7] = rnd ? (8'($urandom) & 8'h0F) : 8'h00;
    case (kind)
      1: img[0] = 8'h4F;
      2: img[4] = 8'h02;
      3: img[6] = img[6] | 8'h04;
      4: img[7] = img[7] | 8'h10;
      default: ;
    endcase
  endtask

  function automatic int first_bad();
    for (int n = 0; n < 16; n++) begin
      bit ok;
      case (n)
        0: ok = (img[0] == 8'h4E);
        1: ok = (img[1] == 8'h45);
        2: ok = (img[2] == 8'h53);
        3: ok = (img[3] == 8'h1A);
        4: ok = (img[4] == 8'd1);
        5: ok = (img[5] == 8'd1);
        6: ok = ((img[6] & 8'hF4) == 8'h00);
        7: ok = ((img[7] & 8'hF0) == 8'h00);
        default: ok = 1'b1;
      endcase
      if (!ok) return n;
    end
    return -1;
  endfunction

  // Monitor: a new ROM write is a rising prog or a changed address while prog is high.
  always @(negedge ppu_clk) begin
    if (rst) begin
      mon_prev_prog = 1'b0;
    end else begin
      if (prog && (!mon_prev_prog || prog_ab != mon_prev_ab)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr 'h%0h data 'h%0h, expected no write", prog_ab, prog_di);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          checkOutput("write_addr", {16'h0, prog_ab}, {16'h0, e[23:8]});
          checkOutput("write_data", {24'h0, prog_di}, {24'h0, e[7:0]});
        end
      end
      mon_prev_prog = prog;
      mon_prev_ab   = prog_ab;
    end
  end

  task automatic sendImage(input bit bp, input int limit, input bit poke_start);
    int idx = 0;
    int cyc = 0;
    bit hold_ok = 1'b1;
    while (idx < limit && cyc < 2 * N + 200) begin
      in_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = img[idx];
      start    = poke_start && (cyc == 100);
      if (cpu_rst !== 1'b1) hold_ok = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back({16'(idx), img[idx]});
        idx++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    checkOutput("accepted_bytes", idx, limit);
    checkOutput("cpu_rst_held", {31'h0, hold_ok}, 32'd1);
  endtask

  task automatic runLoad(input int kind, input bit rnd, input bit bp, input bit poke_start);
    int bad;
    build_image(kind, rnd);
    bad = first_bad();
    applyStimulus();
    checkOutput("start_in_ready", {31'h0, in_ready}, 32'd1);
    checkOutput("start_byte_cnt", {16'h0, byte_cnt}, 32'd0);
    checkOutput("start_done", {31'h0, done}, 32'd0);
    checkOutput("start_err", {31'h0, err}, 32'd0);
    checkOutput("start_cpu_rst", {31'h0, cpu_rst}, 32'd1);
    sendImage(bp, (bad >= 0) ? bad + 1 : N, poke_start);
    if (bad >= 0) begin
      checkOutput("err_set", {31'h0, err}, 32'd1);
      checkOutput("err_prog_hi", {31'h0, prog}, 32'd1);
      checkOutput("err_in_ready", {31'h0, in_ready}, 32'd0);
      checkOutput("err_byte_cnt", {16'h0, byte_cnt}, bad + 1);
      in_valid = 1'b1;
      tick();
      checkOutput("err_prog_lo", {31'h0, prog}, 32'd0);
      repeat (4) tick();
      in_valid = 1'b0;
      checkOutput("err_no_more_bytes", {16'h0, byte_cnt}, bad + 1);
      checkOutput("err_cpu_rst", {31'h0, cpu_rst}, 32'd1);
      checkOutput("err_sticky", {31'h0, err}, 32'd1);
      checkOutput("err_done", {31'h0, done}, 32'd0);
    end else begin
      checkOutput("flush_prog", {31'h0, prog}, 32'd1);
      checkOutput("flush_done", {31'h0, done}, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("done_set", {31'h0, done}, 32'd1);
      checkOutput("done_prog", {31'h0, prog}, 32'd0);
      checkOutput("done_cpu_rst", {31'h0, cpu_rst}, 32'd0);
      checkOutput("done_prog_ab", {16'h0, prog_ab}, 32'd0);
      checkOutput("done_byte_cnt", {16'h0, byte_cnt}, N);
      checkOutput("done_in_ready", {31'h0, in_ready}, 32'd0);
      checkOutput("done_err", {31'h0, err}, 32'd0);
    end
    @(negedge ppu_clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    checkOutput("rst_prog", {31'h0, prog}, 32'd0);
    checkOutput("rst_prog_ab", {16'h0, prog_ab}, 32'd0);
    checkOutput("rst_prog_di", {24'h0, prog_di}, 32'd0);
    checkOutput("rst_cpu_rst", {31'h0, cpu_rst}, 32'd1);
    checkOutput("rst_done", {31'h0, done}, 32'd0);
    checkOutput("rst_err", {31'h0, err}, 32'd0);
    checkOutput("rst_byte_cnt", {16'h0, byte_cnt}, 32'd0);
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] back-to-back valid image");
    runLoad(0, 1'b0, 1'b0, 1'b0);
    $display("[TB] bad magic, NROM-256, trainer");
    runLoad(1, 1'b1, 1'b0, 1'b0);
    runLoad(2, 1'b1, 1'b0, 1'b0);
    runLoad(3, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset mid-load");
    build_image(0, 1'b1);
    applyStimulus();
    sendImage(1'b0, 'h2000, 1'b0);
    @(negedge ppu_clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_prog", {31'h0, prog}, 32'd0);
    checkOutput("midrst_cpu_rst", {31'h0, cpu_rst}, 32'd1);
    checkOutput("midrst_byte_cnt", {16'h0, byte_cnt}, 32'd0);
    checkOutput("midrst_in_ready", {31'h0, in_ready}, 32'd0);
    checkOutput("midrst_prog_ab", {16'h0, prog_ab}, 32'd0);
    checkOutput("midrst_writes_seen", exp_q.size(), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] backpressured random image after reset");
    runLoad(0, 1'b1, 1'b1, 1'b1);

    $display("[TB] restart from DONE with a bad image");
    checkOutput("restart_pre_done", {31'h0, done}, 32'd1);
    runLoad($urandom_range(1, 4), 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Load sequencer for the NROM image store. After reset it holds the CPU in reset and accepts an iNES byte stream over a valid/ready handshake. It validates the 16-byte header (NROM-128, mapper 0, no trainer) and writes every byte of the image into the ROM store's program port. It then drops `prog` and releases the CPU. It shares the ROM store's programming clock domain.

## Interface
- `IMG_BYTES`, default 'h6010: total image length in bytes (16 header + 16 KiB PRG + 8 KiB CHR).
- `ppu_clk`  in  1: sole clock; the ROM store's program-side clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a load. Honoured in IDLE, DONE and ERROR; ignored otherwise.
- `in_data`  in  8: image byte.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `prog`  out  1: ROM store program mode (registered).
- `prog_ab`  out  16: ROM store write address (registered).
- `prog_di`  out  8: ROM store write data (registered).
- `cpu_rst`  out  1: active-high hold for the CPU core. High except in DONE.
- `done`  out  1: image loaded and valid.
- `err`  out  1: header rejected. Sticky until `start` or `rst`.
- `byte_cnt`  out  16: number of bytes accepted in the current load.

## Operation
- States: IDLE, HEADER, BODY, FLUSH, DONE, ERROR.
- `in_ready` is a combinational function of state: 1 in HEADER and BODY, 0 elsewhere.
- A transfer occurs on a clock edge where `in_valid && in_ready`.
- IDLE/DONE/ERROR + `start`:
  - go to HEADER;
  - `byte_cnt` = 0; `done` = 0; `err` = 0; `cpu_rst` = 1.
- Each transfer in HEADER/BODY:
  - `prog_ab` ← `byte_cnt`; `prog_di` ← `in_data`; `prog` ← 1;
  - `byte_cnt` ← `byte_cnt` + 1.
- Between transfers, `prog_ab`/`prog_di` hold their values. The ROM store then rewrites the same byte each cycle, which is idempotent.
- Header checks, made on the transfer of byte index n:
  - n = 0..3 must be 'h4E, 'h45, 'h53, 'h1A.
  - n = 4 (PRG 16K units) must be 1.
  - n = 5 (CHR 8K units) must be 1.
  - n = 6: bits[7:4] = 0 and bit 2 (trainer) = 0.
  - n = 7: bits[7:4] = 0.
  - n = 8..15 are not checked.
- Mismatch on a header byte:
  - next state ERROR; `err` ← 1; the offending byte is still written once;
  - `prog` ← 0 on the following edge; `cpu_rst` stays 1.
- Transfer of n = 15 with no error moves HEADER to BODY.
- Transfer of n = `IMG_BYTES` − 1 moves to FLUSH. FLUSH lasts exactly one cycle so the ROM store samples the last byte with `prog` = 1.
- FLUSH → DONE:
  - `prog` ← 0; `done` ← 1; `cpu_rst` ← 0;
  - `prog_ab` returns to 0.
- `start` in HEADER, BODY or FLUSH is ignored. A load cannot be aborted except by `rst`.
- `byte_cnt` never exceeds `IMG_BYTES` and does not wrap.

## Timing
- Reset values:
  - state IDLE; `prog` = 0; `prog_ab` = 0; `prog_di` = 0;
  - `cpu_rst` = 1; `done` = 0; `err` = 0; `byte_cnt` = 0;
  - `in_ready` = 0.
- `start` sampled at edge t: `in_ready` = 1 from t until the next edge.
- A transfer at edge t: the ROM write occurs at edge t+1 (registered `prog_ab`/`prog_di` with `prog` = 1).
- Sustained throughput is 1 byte per clock with `in_valid` held high. A full image takes `IMG_BYTES` + 1 cycles from the first transfer to DONE (the +1 is FLUSH).
- Gaps in `in_valid` stretch the load with no penalty. Write order is strictly ascending.
- Error at edge t: `err` = 1 and `prog` = 1 after t; `prog` = 0 after t+1. No further transfers occur (`in_ready` = 0 from t).
- `rst` mid-load: all outputs return to reset values immediately (asynchronous). The ROM contents are then partial and a new `start` reloads from byte 0.
- `start` in the same cycle as the final FLUSH edge is ignored. `start` is honoured once the state is DONE.

## Test plan
- Valid image:
  - stimulus: `start`, then 'h6010 bytes back-to-back (header 4E 45 53 1A 01 01 00 00 + 8×00, payload = index[7:0]).
  - required: write addresses 0..'h600F in order with matching data; `prog` falls 1 cycle after the last write edge; `done` = 1; `cpu_rst` = 0; `byte_cnt` = 'h6010.
- Bad magic:
  - stimulus: byte 0 = 'h4F.
  - required: `err` = 1 after the first transfer; `prog` = 0 one cycle later; `in_ready` = 0; `cpu_rst` = 1; `byte_cnt` = 1.
- Unsupported layout:
  - stimulus: byte 4 = 2 (NROM-256), and separately byte 6 = 'h04 (trainer).
  - required: ERROR at `byte_cnt` = 5 and 7 respectively.
- Backpressure:
  - stimulus: valid image with `in_valid` toggled pseudo-randomly.
  - required: identical ROM contents to the back-to-back case; `prog_ab` never skips or repeats an increment.
- Reset mid-load:
  - stimulus: assert `rst` at `byte_cnt` = 'h2000.
  - required: `prog` = 0 and `cpu_rst` = 1 immediately; after release, `start` plus a full image ends in `done`.
- Restart:
  - stimulus: `start` in DONE, then a bad image.
  - required: `done` clears on the `start` edge; `err` is set; `cpu_rst` is held at 1 throughout.
